// File: rtl/fifo_break_dv.sv
// -----------------------------------------------------------------------------
// fifo_break_dv
//
// Elastic FIFO for dataflow circuits. It sits directly downstream of a
// non-transparent merge. The merge's combinational valid/data path and the
// consumer's ready path are both cut by registers. The FIFO holds up to SLOTS
// tokens in a circular buffer and sustains one token per cycle.
//
// Parameters:
//   DATA_TYPE  token data width in bits (>= 1)
//   SLOTS      buffer depth in tokens (>= 2, any value, not only powers of two)
//
// Ports:
//   clk         clock; all state updates on its rising edge
//   rst         asynchronous, active-low reset
//   ins         upstream token data
//   ins_valid   upstream token valid
//   ins_ready   FIFO can accept a token this cycle (depends on state only)
//   outs        token at the head of the FIFO
//   outs_valid  head token valid
//   outs_ready  consumer accepts the head token
//
// Optional feature:
//   FIFO_BREAK_DV_BYPASS_EN  When this macro is defined, a token that arrives
//                            while the FIFO is empty is presented on outs in
//                            the same cycle (zero-latency bypass). This adds a
//                            combinational valid/data path from ins to outs.
//                            When the macro is undefined, the FIFO is fully
//                            registered and latency is at least 1 cycle.
// -----------------------------------------------------------------------------
module fifo_break_dv #(
    parameter int DATA_TYPE = 32,
    parameter int SLOTS     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_TYPE-1:0] ins,
    input  logic                 ins_valid,
    output logic                 ins_ready,
    output logic [DATA_TYPE-1:0] outs,
    output logic                 outs_valid,
    input  logic                 outs_ready
);

    localparam int PTR_W = $clog2(SLOTS);
    localparam int CNT_W = $clog2(SLOTS + 1);

    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(SLOTS - 1);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(SLOTS);

    logic [DATA_TYPE-1:0] mem [0:SLOTS-1];
    logic [PTR_W-1:0]     head;
    logic [PTR_W-1:0]     tail;
    logic [CNT_W-1:0]     count;

    logic empty;
    logic full;
    logic pass_thru;
    logic push;
    logic pop;
    logic [PTR_W-1:0] head_next;
    logic [PTR_W-1:0] tail_next;

    assign empty = (count == '0);
    assign full  = (count == FULL_CNT);

    // Ready is a function of the registered count only. While rst is low it
    // is forced low, and it rises combinationally the moment rst is released.
    assign ins_ready = !full && rst;

`ifdef FIFO_BREAK_DV_BYPASS_EN
    // Empty FIFO with a waiting consumer: the token goes straight through and
    // never touches the buffer. Gating with rst keeps outs quiet during reset.
    assign pass_thru  = empty && ins_valid && outs_ready && rst;
    assign outs_valid = rst && (!empty || ins_valid);
    assign outs       = !rst ? '0 : (empty ? ins : mem[head]);
`else
    assign pass_thru  = 1'b0;
    assign outs_valid = !empty;
    assign outs       = mem[head];
`endif

    // A stored token is written only if it is not bypassed. A stored token is
    // read only if the FIFO is non-empty. A bypass happens only when the FIFO
    // is empty, so a bypass never pops a stored entry.
    assign push = ins_valid && ins_ready && !pass_thru;
    assign pop  = outs_valid && outs_ready && !empty;

    // The wrap is explicit because SLOTS need not be a power of two.
    assign head_next = (head == LAST_PTR) ? '0 : head + PTR_W'(1);
    assign tail_next = (tail == LAST_PTR) ? '0 : tail + PTR_W'(1);

    // NOTE: state registers use non-blocking assignments. Every flop then
    // samples the pre-edge values of its neighbours, whatever the order of the
    // statements.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            // NOTE: the storage is cleared on reset as well. The registered
            // outs reads mem[head] directly, and it must be 0 while reset is
            // held and immediately after reset.
            for (int i = 0; i < SLOTS; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[tail] <= ins;
                tail      <= tail_next;
            end
            if (pop) begin
                head <= head_next;
            end
            unique case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_break_dv.sv
// -----------------------------------------------------------------------------
// tb_fifo_break_dv
//
// Directed bench for fifo_break_dv in its registered (non-bypass) build, with
// SLOTS=3 and 8-bit tokens. Inputs change 1 time unit after each rising edge.
// Outputs are sampled 1 time unit later again, well away from the next edge.
// -----------------------------------------------------------------------------
module tb_fifo_break_dv;

    localparam int W     = 8;
    localparam int SLOTS = 3;

    logic         clk;
    logic         rst;
    logic [W-1:0] ins;
    logic         ins_valid;
    logic         ins_ready;
    logic [W-1:0] outs;
    logic         outs_valid;
    logic         outs_ready;

    int checks   = 0;
    int failures = 0;

    fifo_break_dv #(
        .DATA_TYPE (W),
        .SLOTS     (SLOTS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ins        (ins),
        .ins_valid  (ins_valid),
        .ins_ready  (ins_ready),
        .outs       (outs),
        .outs_valid (outs_valid),
        .outs_ready (outs_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Advance one edge, then settle to the mid-cycle drive point.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int sent;
        int recv;
        int occ;
        logic do_push;
        logic do_pop;

        // ---------------- reset held with ins_valid high ----------------
        rst        = 1'b0;
        ins        = 8'hEE;
        ins_valid  = 1'b1;
        outs_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            #1;
            check("rst_outs_valid", 32'(outs_valid), 32'd0);
            check("rst_outs",       32'(outs),       32'd0);
            check("rst_ins_ready",  32'(ins_ready),  32'd0);
        end
        ins_valid = 1'b0;
        rst       = 1'b1;
        #1;
        check("release_ins_ready",  32'(ins_ready),  32'd1);
        check("release_outs_valid", 32'(outs_valid), 32'd0);
        tick();
        #1;
        check("nothing_stored", 32'(outs_valid), 32'd0);

        // ---------------- streaming, one token per cycle ----------------
        outs_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            ins       = W'(8'h10 + i);
            ins_valid = 1'b1;
            tick();
            #1;
            check("stream_data",      32'(outs),       32'(8'h10 + i));
            check("stream_valid",     32'(outs_valid), 32'd1);
            check("stream_ins_ready", 32'(ins_ready),  32'd1);
        end
        ins_valid = 1'b0;
        tick();
        #1;
        check("stream_drained", 32'(outs_valid), 32'd0);

        // ---------------- fill to full, then drain ----------------
        outs_ready = 1'b0;
        ins_valid  = 1'b1;
        ins = 8'h0A; tick(); #1; check("fill1_ready", 32'(ins_ready), 32'd1);
        ins = 8'h0B; tick(); #1; check("fill2_ready", 32'(ins_ready), 32'd1);
        ins = 8'h0C; tick(); #1; check("fill3_ready", 32'(ins_ready), 32'd0);
        ins = 8'h0D; tick(); #1;
        check("full_held_ready", 32'(ins_ready),  32'd0);
        check("full_head_data",  32'(outs),       32'h0A);
        check("full_head_valid", 32'(outs_valid), 32'd1);
        outs_ready = 1'b1;
        #1;
        check("drain_a", 32'(outs), 32'h0A);
        tick(); #1;
        check("ready_after_pop", 32'(ins_ready), 32'd1);
        check("drain_b",         32'(outs),      32'h0B);
        tick(); #1;
        ins_valid = 1'b0;
        check("drain_c", 32'(outs), 32'h0C);
        tick(); #1;
        check("drain_d",       32'(outs),       32'h0D);
        check("drain_d_valid", 32'(outs_valid), 32'd1);
        tick(); #1;
        check("drain_empty", 32'(outs_valid), 32'd0);

        // ---------------- wrap with random stalls on both sides ----------------
        sent = 0;
        recv = 0;
        for (int cyc = 0; cyc < 300 && recv < 10; cyc++) begin
            ins_valid  = (sent < 10) && ($urandom_range(0, 2) != 0);
            ins        = W'(8'h20 + sent);
            outs_ready = ($urandom_range(0, 2) != 0);
            #1;
            occ = sent - recv;
            check("wrap_valid", 32'(outs_valid), 32'(occ > 0));
            check("wrap_ready", 32'(ins_ready),  32'(occ < SLOTS));
            if (occ > 0) begin
                check("wrap_data", 32'(outs), 32'(8'h20 + recv));
            end
            do_push = ins_valid && (occ < SLOTS);
            do_pop  = outs_ready && (occ > 0);
            tick();
            if (do_push) sent++;
            if (do_pop)  recv++;
        end
        check("wrap_all_received", 32'(recv), 32'd10);
        ins_valid  = 1'b0;
        outs_ready = 1'b0;

        // ---------------- reset mid-operation ----------------
        ins_valid = 1'b1;
        ins = 8'h31; tick();
        ins = 8'h32; tick();
        ins_valid = 1'b0;
        #1;
        check("pre_rst_valid", 32'(outs_valid), 32'd1);
        rst = 1'b0;
        #1;
        check("mid_rst_valid", 32'(outs_valid), 32'd0);
        check("mid_rst_outs",  32'(outs),       32'd0);
        check("mid_rst_ready", 32'(ins_ready),  32'd0);
        tick();
        rst       = 1'b1;
        ins       = 8'h55;
        ins_valid = 1'b1;
        tick();
        ins_valid = 1'b0;
        #1;
        check("post_rst_first", 32'(outs),       32'h55);
        check("post_rst_valid", 32'(outs_valid), 32'd1);
        outs_ready = 1'b1;
        tick(); #1;
        check("post_rst_only_one", 32'(outs_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
